// File: rtl/fp_accum_seq.sv
// Reduction sequencer: streams operands into a downstream pipelined FP adder,
// keeping one addition in flight and feeding each result back as the accumulator.
module fp_accum_seq #(
    parameter int expWidth = 8,
    parameter int sigWidth = 24,
    parameter int numWidth = 32,
    parameter int cntWidth = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [cntWidth-1:0] count,
    input  logic                subtract,
    input  logic [2:0]          roundingMode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [numWidth-1:0] in_data,
    output logic                add_val,
    output logic                add_subOp,
    output logic [numWidth-1:0] add_a,
    output logic [numWidth-1:0] add_b,
    output logic [2:0]          add_roundingMode,
    input  logic [numWidth-1:0] add_out,
    input  logic [4:0]          add_flags,
    input  logic                add_done,
    output logic [numWidth-1:0] sum,
    output logic [4:0]          flags,
    output logic                done
);

    // +0.0 assembled from its fields: sign, exponent, stored fraction
    localparam logic [numWidth-1:0] POS_ZERO = {1'b0, {expWidth{1'b0}}, {(sigWidth-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, FINISH} state_t;

    state_t                state_reg, state_next;
    logic [numWidth-1:0]   acc_reg, acc_next;
    logic [cntWidth-1:0]   rem_reg, rem_next;
    logic [4:0]            flag_acc_reg, flag_acc_next;
    logic                  sub_reg, sub_next;
    logic [2:0]            rm_reg, rm_next;
    logic                  add_val_reg, add_val_next;
    logic                  add_sub_reg, add_sub_next;
    logic [numWidth-1:0]   add_a_reg, add_a_next;
    logic [numWidth-1:0]   add_b_reg, add_b_next;
    logic [2:0]            add_rm_reg, add_rm_next;
    logic [numWidth-1:0]   sum_reg, sum_next;
    logic [4:0]            flags_reg, flags_next;
    logic                  done_reg, done_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            rem_reg      <= '0;
            flag_acc_reg <= '0;
            sub_reg      <= 1'b0;
            rm_reg       <= '0;
            add_val_reg  <= 1'b0;
            add_sub_reg  <= 1'b0;
            add_a_reg    <= '0;
            add_b_reg    <= '0;
            add_rm_reg   <= '0;
            sum_reg      <= '0;
            flags_reg    <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            rem_reg      <= rem_next;
            flag_acc_reg <= flag_acc_next;
            sub_reg      <= sub_next;
            rm_reg       <= rm_next;
            add_val_reg  <= add_val_next;
            add_sub_reg  <= add_sub_next;
            add_a_reg    <= add_a_next;
            add_b_reg    <= add_b_next;
            add_rm_reg   <= add_rm_next;
            sum_reg      <= sum_next;
            flags_reg    <= flags_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        rem_next      = rem_reg;
        flag_acc_next = flag_acc_reg;
        sub_next      = sub_reg;
        rm_next       = rm_reg;
        add_val_next  = 1'b0;
        add_sub_next  = add_sub_reg;
        add_a_next    = add_a_reg;
        add_b_next    = add_b_reg;
        add_rm_next   = add_rm_reg;
        sum_next      = sum_reg;
        flags_next    = flags_reg;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (go) begin
                    sub_next      = subtract;
                    rm_next       = roundingMode;
                    acc_next      = POS_ZERO;
                    flag_acc_next = '0;
                    if (count == '0) begin
                        state_next = FINISH;
                    end else begin
                        rem_next   = count;
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                if (in_valid) begin
                    add_a_next   = acc_reg;
                    add_b_next   = in_data;
                    add_sub_next = sub_reg;
                    add_rm_next  = rm_reg;
                    add_val_next = 1'b1;
                    // only decremented when nonzero, so it can never wrap
                    if (rem_reg != '0) begin
                        rem_next = rem_reg - cntWidth'(1);
                    end
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // adder operands stay untouched here; the adder samples them late
                if (add_done) begin
                    acc_next      = add_out;
                    flag_acc_next = flag_acc_reg | add_flags;
                    state_next    = (rem_reg == '0) ? FINISH : FETCH;
                end
            end
            FINISH: begin
                sum_next   = acc_reg;
                flags_next = flag_acc_reg;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready         = (state_reg == FETCH);
    assign add_val          = add_val_reg;
    assign add_subOp        = add_sub_reg;
    assign add_a            = add_a_reg;
    assign add_b            = add_b_reg;
    assign add_roundingMode = add_rm_reg;
    assign sum              = sum_reg;
    assign flags            = flags_reg;
    assign done             = done_reg;

endmodule
